// File: rtl/bsort_pkg.sv
// Shared definitions for the bubble-sort sequencer: FSM state encoding,
// default widths and the swap counter width helper.
package bsort_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_RD_B  = 3'd2,
        S_CMP   = 3'd3,
        S_WR_LO = 3'd4,
        S_WR_HI = 3'd5,
        S_DONE  = 3'd6
    } bsort_state_e;

    // Worst case is n(n-1)/2 swaps for n = 2^addr_w, which fits in 2*addr_w bits.
    function automatic int swap_cnt_w(input int addr_w);
        return 2 * addr_w;
    endfunction

endpackage

// File: rtl/bsort_swap_dp.sv
// Compare/swap datapath: holds the two words under comparison, decides
// whether they are out of order (strictly greater, so equal keys stay put)
// and selects which held word goes to the RAM on a write.
module bsort_swap_dp #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_a_i,
    input  logic              load_b_i,
    input  logic              sel_hi_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              gt_o,
    output logic [DATA_W-1:0] wdata_o
);

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;

    // Capture the lower-address word, then the upper-address word, as the reads return.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (load_a_i) a_q <= rdata_i;
            if (load_b_i) b_q <= rdata_i;
        end
    end

    // The second word is compared straight off the RAM bus in the cycle it arrives.
    always_comb begin
        gt_o = (a_q > rdata_i);
    end

    // Swapped write order: upper word goes low first, then the lower word goes high.
    always_comb begin
        wdata_o = sel_hi_i ? a_q : b_q;
    end

endmodule

// File: rtl/bubble_sort_ctrl.sv
// In-place bubble-sort sequencer driving a single-port RAM with one-cycle
// registered read data. Sorts the first len words ascending (unsigned, stable).
// Build option: define BSORT_EARLY_EXIT_EN to end the sort after a pass
// that made no swap; otherwise all len-1 passes always run.
//
// Handshake: start is sampled only while busy is low; once accepted, len is
// captured and not re-read, further start pulses are ignored until the
// single-cycle done pulse, after which busy falls and the RAM belongs to the host.
module bubble_sort_ctrl
    import bsort_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [ADDR_W:0]                   len,
    output logic                              busy,
    output logic                              done,
    output logic [swap_cnt_w(ADDR_W)-1:0]     swap_count,
    output logic                              mem_en,
    output logic                              mem_rw,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [DATA_W-1:0]                 mem_wdata,
    input  logic [DATA_W-1:0]                 mem_rdata,
    output bsort_state_e                      dbg_state
);

    localparam int SCW = swap_cnt_w(ADDR_W);
    localparam logic [ADDR_W:0] LEN_TWO = (ADDR_W + 1)'(2);

    bsort_state_e      state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [ADDR_W-1:0] hi_q, hi_d;
    logic              swapped_q, swapped_d;
    logic [SCW-1:0]    swap_cnt_q, swap_cnt_d;

    logic              advance;
    logic              early_exit;
    logic              dp_gt;
    logic [DATA_W-1:0] dp_wdata;
    logic [ADDR_W-1:0] i_p1;

    assign i_p1 = i_q + ADDR_W'(1);

    bsort_swap_dp #(
        .DATA_W (DATA_W)
    ) u_swap_dp (
        .clk      (clk),
        .rst      (rst),
        .load_a_i (state_q == S_RD_B),
        .load_b_i (state_q == S_CMP),
        .sel_hi_i (state_q == S_WR_HI),
        .rdata_i  (mem_rdata),
        .gt_o     (dp_gt),
        .wdata_o  (dp_wdata)
    );

    // A pass with no swap means the remaining prefix is already ordered.
`ifdef BSORT_EARLY_EXIT_EN
    logic swapped_now;
    assign swapped_now = swapped_q | (state_q == S_WR_HI);
    assign early_exit  = ~swapped_now;
`else
    assign early_exit  = 1'b0;
`endif

    // State, pass bounds and swap statistics register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            hi_q       <= '0;
            swapped_q  <= 1'b0;
            swap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            hi_q       <= hi_d;
            swapped_q  <= swapped_d;
            swap_cnt_q <= swap_cnt_d;
        end
    end

    // Next-state logic; advance is the shared "move to next pair / next pass" step.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        hi_d       = hi_q;
        swapped_d  = swapped_q;
        swap_cnt_d = swap_cnt_q;
        advance    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    swap_cnt_d = '0;
                    if (len < LEN_TWO) begin
                        state_d = S_DONE;
                    end else begin
                        i_d       = '0;
                        hi_d      = ADDR_W'(len - LEN_TWO);
                        swapped_d = 1'b0;
                        state_d   = S_RD_A;
                    end
                end
            end
            S_RD_A:  state_d = S_RD_B;
            S_RD_B:  state_d = S_CMP;
            S_CMP: begin
                if (dp_gt) state_d = S_WR_LO;
                else       advance = 1'b1;
            end
            S_WR_LO: state_d = S_WR_HI;
            S_WR_HI: begin
                swapped_d  = 1'b1;
                swap_cnt_d = swap_cnt_q + SCW'(1);
                advance    = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (i_q < hi_q) begin
                i_d     = i_q + ADDR_W'(1);
                state_d = S_RD_A;
            end else if ((hi_q == '0) || early_exit) begin
                state_d = S_DONE;
            end else begin
                i_d       = '0;
                hi_d      = hi_q - ADDR_W'(1);
                swapped_d = 1'b0;
                state_d   = S_RD_A;
            end
        end
    end

    // RAM strobes decoded from the registered state; all zero when not accessing.
    always_comb begin
        mem_en    = 1'b0;
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_RD_A: begin
                mem_en   = 1'b1;
                mem_addr = i_q;
            end
            S_RD_B: begin
                mem_en   = 1'b1;
                mem_addr = i_p1;
            end
            S_WR_LO: begin
                mem_en    = 1'b1;
                mem_rw    = 1'b1;
                mem_addr  = i_q;
                mem_wdata = dp_wdata;
            end
            S_WR_HI: begin
                mem_en    = 1'b1;
                mem_rw    = 1'b1;
                mem_addr  = i_p1;
                mem_wdata = dp_wdata;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign swap_count = swap_cnt_q;
    assign dbg_state  = state_q;

endmodule
